ven_dispense: RTL and testbench
===============================

Name: ven_dispense

Overview:
- Output-side controller for the vending machine: consumes the one-cycle product and change pulses the coin FSM emits and drives the physical actuators.
- Drives the product motor and the coin-return hopper, waits for the sensor handshake, and queues requests that arrive while an actuator is busy.
- Detects jammed actuators with a timeout and latches a fault until it is explicitly cleared.

Parameters:
- QDEPTH, 3, max pending requests per queue (product and change); 1..7.
- TIMEOUT, 1000, cycles an actuator may stay on without its done sensor before a fault.
- GAP_CYC, 4, minimum actuator-off cycles between consecutive operations.
- TO_W, 10, width of timeout counter; must hold TIMEOUT.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous, active-low reset.
- product  in  1  one-cycle request: vend one item.
- change  in  1  one-cycle request: return one coin.
- vend_done  in  1  motor home/complete sensor, level, synchronous to clk.
- coin_out  in  1  hopper coin-ejected sensor, level, synchronous to clk.
- fault_clr  in  1  one-cycle pulse that leaves FAULT.
- motor_en  out  1  product motor drive.
- hopper_en  out  1  coin hopper drive.
- busy  out  1  state != IDLE or any request pending.
- fault  out  1  high while in FAULT.
- ovf  out  1  sticky: a request was dropped because its queue was full.

Behaviour:
- Reset (rst_n low, async): state=IDLE, prod_cnt=0, chg_cnt=0, timer=0, all outputs 0. Reset mid-operation drops actuators immediately and discards the queues.
- All outputs are registered.
- Queues: prod_cnt/chg_cnt are 3-bit up/down counters.
  - product=1 increments prod_cnt; change=1 increments chg_cnt. Both may be high in the same cycle.
  - An increment at QDEPTH is dropped and sets ovf. ovf clears only on reset.
  - Same-cycle increment and completion-decrement gives a net change of 0.
- States: IDLE, VEND, PAY, GAP, FAULT.
- IDLE:
  - prod_cnt>0 → VEND. motor_en=1 from the next cycle; request-to-motor latency is 2 cycles from the product pulse.
  - else chg_cnt>0 → PAY. hopper_en=1 next cycle.
  - Product always has priority over change, so a product and its change vend in that order.
- VEND: motor_en=1, timer increments each cycle.
  - vend_done=1 → prod_cnt−1, motor_en=0, timer=0, → GAP.
  - timer==TIMEOUT−1 without vend_done → FAULT. prod_cnt is not decremented.
- PAY: same as VEND but uses hopper_en and coin_out, and decrements chg_cnt.
- GAP: actuators off, timer counts.
  - Exit to IDLE when timer≥GAP_CYC−1 AND vend_done=0 AND coin_out=0. A stuck-high sensor holds GAP.
  - GAP has no timeout.
- FAULT: motor_en=hopper_en=0, fault=1.
  - Queues keep counting new requests.
  - fault_clr=1 → IDLE with timer=0. The failed request stays pending and retries.
  - fault_clr outside FAULT is ignored.
- Sensor input while its actuator is off (e.g. vend_done in IDLE or PAY) is ignored.
- busy is combinational OR of (state!=IDLE, prod_cnt!=0, chg_cnt!=0), registered.

Decomposition:
- Shared package ven_pkg holds:
  - state encoding constants IDLE/VEND/PAY/GAP/FAULT (3 bits);
  - the coin codes one=2'b01, two=2'b10, shared with the coin FSM.
- One natural sub-module, ven_req_q: saturating up/down pending counter with ovf.
  - Instantiated twice, once for the product queue and once for the change queue.

Test Plan:
- Single vend:
  - Stimulus: product pulse at cycle 0; vend_done high at cycle 5 for 1 cycle.
  - Response: motor_en=1 cycles 2..5, 0 at 6; GAP for 4 cycles; busy=0 and state IDLE after.
- Product+change together:
  - Stimulus: product=change=1 in one cycle.
  - Response: motor_en first, then after vend_done and GAP, hopper_en=1 until coin_out; chg_cnt ends 0.
- Queue saturation:
  - Stimulus: 4 product pulses while motor is held on with no vend_done.
  - Response: prod_cnt=3, ovf=1; exactly 3 vends complete once vend_done is pulsed 3 times.
- Timeout and clear:
  - Stimulus: product pulse, no vend_done for 1000 cycles.
  - Response: fault=1, motor_en=0. A fault_clr pulse gives motor_en=1 again 2 cycles later; prod_cnt is still 1.
- Stuck sensor:
  - Stimulus: vend_done held high after completion.
  - Response: stays in GAP with no new motor_en despite pending product; releasing vend_done resumes the vend.
- Async reset:
  - Stimulus: rst_n low mid-PAY (not aligned to clk).
  - Response: hopper_en=0 immediately; counters 0; ovf 0; fault 0.

Source files
------------

// File: rtl/ven_pkg.sv
// ven_pkg: shared definitions for the vending-machine output side.
//   ven_state_e : dispense controller state encoding (3 bits)
//   COIN_ONE/TWO: coin codes shared with the coin FSM
//   CNT_W       : width of the pending-request counters
package ven_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    VEND  = 3'd1,
    PAY   = 3'd2,
    GAP   = 3'd3,
    FAULT = 3'd4
  } ven_state_e;

  localparam logic [1:0] COIN_ONE = 2'b01;
  localparam logic [1:0] COIN_TWO = 2'b10;

  localparam int CNT_W = 3;

endpackage

// File: rtl/ven_req_q.sv
// ven_req_q: saturating pending-request counter.
//   clk, rst_n : clock, async active-low reset
//   up         : one-cycle request (increment)
//   dn         : one-cycle completion (decrement)
//   cnt        : registered pending count
//   cnt_nxt    : count after the coming edge (lets the parent register busy in step)
//   drop       : request discarded this cycle because the counter is at QDEPTH
module ven_req_q
  import ven_pkg::*;
#(
  parameter int QDEPTH = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             up,
  input  logic             dn,
  output logic [CNT_W-1:0] cnt,
  output logic [CNT_W-1:0] cnt_nxt,
  output logic             drop
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    drop  = 1'b0;
    case ({up, dn})
      2'b10: begin
        if (cnt_q == CNT_W'(QDEPTH)) drop  = 1'b1;
        else                         cnt_d = cnt_q + 1'b1;
      end
      2'b01: begin
        if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
      end
      // up and dn together: one in, one out, net zero even when full
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign cnt     = cnt_q;
  assign cnt_nxt = cnt_d;

endmodule

// File: rtl/ven_dispense.sv
// ven_dispense: drives the product motor and coin hopper from the coin FSM's
// product/change pulses, with request queues, inter-operation gap and jam timeout.
//   clk, rst_n         : clock, async active-low reset
//   product, change    : one-cycle requests (vend one item / return one coin)
//   vend_done, coin_out: actuator completion sensors (levels, clk-synchronous)
//   fault_clr          : pulse that leaves FAULT
//   motor_en, hopper_en: actuator drives
//   busy               : not idle or requests pending
//   fault              : in FAULT
//   ovf                : sticky, a request was dropped on a full queue
//
// state | meaning
// IDLE  | nothing running; picks product first, then change
// VEND  | motor on, waiting for vend_done or timeout
// PAY   | hopper on, waiting for coin_out or timeout
// GAP   | actuators off for a minimum time and until both sensors are low
// FAULT | actuator jammed; waits for fault_clr, request stays queued
module ven_dispense
  import ven_pkg::*;
#(
  parameter int QDEPTH  = 3,
  parameter int TIMEOUT = 1000,
  parameter int GAP_CYC = 4,
  parameter int TO_W    = 10
) (
  input  logic clk,
  input  logic rst_n,
  input  logic product,
  input  logic change,
  input  logic vend_done,
  input  logic coin_out,
  input  logic fault_clr,
  output logic motor_en,
  output logic hopper_en,
  output logic busy,
  output logic fault,
  output logic ovf
);

  ven_state_e       state_q, state_d;
  logic [TO_W-1:0]  timer_q, timer_d;
  logic             motor_en_q, motor_en_d;
  logic             hopper_en_q, hopper_en_d;
  logic             busy_q, busy_d;
  logic             fault_q, fault_d;
  logic             ovf_q, ovf_d;

  logic             prod_dn, chg_dn;
  logic             prod_drop, chg_drop;
  logic [CNT_W-1:0] prod_cnt, prod_cnt_nxt;
  logic [CNT_W-1:0] chg_cnt, chg_cnt_nxt;

  ven_req_q #(.QDEPTH(QDEPTH)) u_prod_q (
    .clk     (clk),
    .rst_n   (rst_n),
    .up      (product),
    .dn      (prod_dn),
    .cnt     (prod_cnt),
    .cnt_nxt (prod_cnt_nxt),
    .drop    (prod_drop)
  );

  ven_req_q #(.QDEPTH(QDEPTH)) u_chg_q (
    .clk     (clk),
    .rst_n   (rst_n),
    .up      (change),
    .dn      (chg_dn),
    .cnt     (chg_cnt),
    .cnt_nxt (chg_cnt_nxt),
    .drop    (chg_drop)
  );

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    prod_dn = 1'b0;
    chg_dn  = 1'b0;

    case (state_q)
      IDLE: begin
        timer_d = '0;
        if (prod_cnt != '0)     state_d = VEND;
        else if (chg_cnt != '0) state_d = PAY;
      end
      VEND: begin
        if (vend_done) begin
          prod_dn = 1'b1;
          timer_d = '0;
          state_d = GAP;
        end else if (timer_q == TO_W'(TIMEOUT - 1)) begin
          timer_d = '0;
          state_d = FAULT;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      PAY: begin
        if (coin_out) begin
          chg_dn  = 1'b1;
          timer_d = '0;
          state_d = GAP;
        end else if (timer_q == TO_W'(TIMEOUT - 1)) begin
          timer_d = '0;
          state_d = FAULT;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      GAP: begin
        // Timer saturates so a stuck sensor can hold GAP indefinitely without wrap.
        if (timer_q >= TO_W'(GAP_CYC - 1)) begin
          if (!vend_done && !coin_out) begin
            timer_d = '0;
            state_d = IDLE;
          end
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      FAULT: begin
        timer_d = '0;
        if (fault_clr) state_d = IDLE;
      end
      default: begin
        timer_d = '0;
        state_d = IDLE;
      end
    endcase

    // Outputs are decoded from the next state so they line up with state_q.
    motor_en_d  = (state_d == VEND);
    hopper_en_d = (state_d == PAY);
    fault_d     = (state_d == FAULT);
    busy_d      = (state_d != IDLE) || (prod_cnt_nxt != '0) || (chg_cnt_nxt != '0);
    ovf_d       = ovf_q || prod_drop || chg_drop;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      timer_q     <= '0;
      motor_en_q  <= 1'b0;
      hopper_en_q <= 1'b0;
      busy_q      <= 1'b0;
      fault_q     <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      motor_en_q  <= motor_en_d;
      hopper_en_q <= hopper_en_d;
      busy_q      <= busy_d;
      fault_q     <= fault_d;
      ovf_q       <= ovf_d;
    end
  end

  assign motor_en  = motor_en_q;
  assign hopper_en = hopper_en_q;
  assign busy      = busy_q;
  assign fault     = fault_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_ven_dispense.sv
module tb_ven_dispense;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic product = 1'b0, change = 1'b0, vend_done = 1'b0, coin_out = 1'b0, fault_clr = 1'b0;
  logic motor_en, hopper_en, busy, fault, ovf;

  int checks = 0;
  int errors = 0;

  ven_dispense dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .product   (product),
    .change    (change),
    .vend_done (vend_done),
    .coin_out  (coin_out),
    .fault_clr (fault_clr),
    .motor_en  (motor_en),
    .hopper_en (hopper_en),
    .busy      (busy),
    .fault     (fault),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    product = 0; change = 0; vend_done = 0; coin_out = 0; fault_clr = 0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    int on_cnt, guard, vends, pays, age_m, age_h, dly_m, dly_h;
    int p_m, c_m, acc_p, acc_c, done_p, done_c;
    bit ovf_m, dp, dc;

    // ---- reset state
    tick();
    chk("rst_motor", motor_en, 0);
    chk("rst_hopper", hopper_en, 0);
    chk("rst_busy", busy, 0);
    chk("rst_fault", fault, 0);
    chk("rst_ovf", ovf, 0);
    do_reset();

    // ---- single vend: motor cycles 2..5, GAP 6..9, idle at 10
    product = 1; tick(); product = 0;
    for (int cyc = 1; cyc <= 11; cyc++) begin
      chk("t1_motor", motor_en, (cyc >= 2 && cyc <= 5));
      chk("t1_busy", busy, (cyc <= 9));
      vend_done = (cyc == 5);
      tick();
    end
    vend_done = 0;

    // ---- product + change together: motor 2..4, hopper 10..12, idle 17
    product = 1; change = 1; tick(); product = 0; change = 0;
    for (int cyc = 1; cyc <= 18; cyc++) begin
      chk("t2_motor", motor_en, (cyc >= 2 && cyc <= 4));
      chk("t2_hopper", hopper_en, (cyc >= 10 && cyc <= 12));
      chk("t2_busy", busy, (cyc <= 16));
      vend_done = (cyc == 4);
      coin_out  = (cyc == 12);
      tick();
    end
    vend_done = 0; coin_out = 0;

    // ---- queue saturation: 4 pulses, 3 accepted, ovf
    do_reset();
    for (int cyc = 0; cyc <= 3; cyc++) begin
      product = 1;
      if (cyc == 3) chk("t3_ovf_before", ovf, 0);
      tick();
    end
    product = 0;
    chk("t3_ovf", ovf, 1);
    chk("t3_motor_held", motor_en, 1);
    vends = 0; age_m = 0;
    for (int k = 0; k < 200; k++) begin
      vend_done = motor_en && (age_m == 3);
      if (vend_done) vends++;
      age_m = motor_en ? (vend_done ? 0 : age_m + 1) : 0;
      tick();
    end
    vend_done = 0;
    chk("t3_vends", vends, 3);
    chk("t3_busy_end", busy, 0);
    chk("t3_ovf_sticky", ovf, 1);

    // ---- timeout, change queued during fault, clear and retry
    do_reset();
    product = 1; tick(); product = 0;
    tick();
    chk("t4_motor_on", motor_en, 1);
    on_cnt = 0;
    while (motor_en && on_cnt < 1100) begin
      on_cnt++;
      tick();
    end
    chk("t4_on_cycles", on_cnt, 1000);
    chk("t4_fault", fault, 1);
    chk("t4_motor_off", motor_en, 0);
    change = 1; tick(); change = 0;
    chk("t4_fault_hold", fault, 1);
    chk("t4_busy_fault", busy, 1);
    tick();
    fault_clr = 1; tick(); fault_clr = 0;
    chk("t4_clr_fault", fault, 0);
    chk("t4_clr_motor0", motor_en, 0);
    tick();
    chk("t4_retry_motor", motor_en, 1);
    chk("t4_retry_hopper", hopper_en, 0);
    vends = 0; pays = 0; age_m = 0; age_h = 0;
    for (int k = 0; k < 60; k++) begin
      if (hopper_en && vends == 0) chk("t4_order", vends, 1);
      vend_done = motor_en && (age_m == 2);
      coin_out  = hopper_en && (age_h == 2);
      if (vend_done) vends++;
      if (coin_out) pays++;
      age_m = motor_en ? (vend_done ? 0 : age_m + 1) : 0;
      age_h = hopper_en ? (coin_out ? 0 : age_h + 1) : 0;
      tick();
    end
    vend_done = 0; coin_out = 0;
    chk("t4_vends", vends, 1);
    chk("t4_pays", pays, 1);
    chk("t4_busy_end", busy, 0);

    // ---- stuck sensor holds GAP; release resumes the second vend
    do_reset();
    product = 1; tick(); tick(); product = 0;
    for (int cyc = 2; cyc <= 24; cyc++) begin
      chk("t5_motor", motor_en, ((cyc >= 2 && cyc <= 4) || cyc >= 23));
      chk("t5_busy", busy, 1);
      vend_done = (cyc >= 4 && cyc <= 20);
      tick();
    end
    vend_done = 1; tick(); vend_done = 0;
    guard = 0;
    while (busy && guard < 50) begin
      guard++;
      tick();
    end
    chk("t5_drained", busy, 0);
    chk("t5_motor_end", motor_en, 0);

    // ---- async reset mid-PAY
    do_reset();
    for (int cyc = 0; cyc <= 3; cyc++) begin
      change = 1;
      tick();
    end
    change = 0;
    tick();
    chk("t6_hopper_on", hopper_en, 1);
    chk("t6_ovf_set", ovf, 1);
    #3 rst_n = 0;
    #1;
    chk("t6_hopper_rst", hopper_en, 0);
    chk("t6_ovf_rst", ovf, 0);
    chk("t6_busy_rst", busy, 0);
    chk("t6_fault_rst", fault, 0);
    tick();
    rst_n = 1;
    for (int k = 0; k < 10; k++) begin
      tick();
      chk("t6_hopper_after", hopper_en, 0);
      chk("t6_busy_after", busy, 0);
    end

    // ---- randomized traffic against a pending-count model
    do_reset();
    p_m = 0; c_m = 0; acc_p = 0; acc_c = 0; done_p = 0; done_c = 0; ovf_m = 0;
    age_m = 0; age_h = 0;
    dly_m = $urandom_range(6, 0);
    dly_h = $urandom_range(6, 0);
    for (int k = 0; k < 2400; k++) begin
      if (k >= 300 && !busy && p_m == 0 && c_m == 0) break;
      product   = (k < 300) && ($urandom_range(5, 0) == 0);
      change    = (k < 300) && ($urandom_range(5, 0) == 0);
      vend_done = motor_en && (age_m >= dly_m);
      coin_out  = hopper_en && (age_h >= dly_h);
      if (motor_en && hopper_en) chk("rnd_exclusive", 1, 0);
      dp = vend_done;
      dc = coin_out;
      if (product) begin
        if (p_m == 3 && !dp) ovf_m = 1;
        else begin p_m++; acc_p++; end
      end
      if (change) begin
        if (c_m == 3 && !dc) ovf_m = 1;
        else begin c_m++; acc_c++; end
      end
      if (dp) begin p_m--; done_p++; end
      if (dc) begin c_m--; done_c++; end
      if (motor_en) begin
        if (vend_done) begin age_m = 0; dly_m = $urandom_range(6, 0); end
        else age_m++;
      end else age_m = 0;
      if (hopper_en) begin
        if (coin_out) begin age_h = 0; dly_h = $urandom_range(6, 0); end
        else age_h++;
      end else age_h = 0;
      tick();
    end
    product = 0; change = 0; vend_done = 0; coin_out = 0;
    chk("rnd_drained", busy, 0);
    chk("rnd_vends", done_p, acc_p);
    chk("rnd_pays", done_c, acc_c);
    chk("rnd_ovf", ovf, ovf_m);
    chk("rnd_fault", fault, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
